// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the I2S transmitter.
// The stereo pair type is sized by SAMPLE_W; the top's WIDTH must equal it.
package i2s_pkg;

    localparam int SAMPLE_W = 24;
    localparam int SLOT_W   = 32;

    function automatic int cnt_width(int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

    localparam int BIT_CNT_W = cnt_width(SLOT_W);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample handshake plus serial bus of the I2S transmitter.
// master = upstream sample source / bus observer, slave = transmitter.
interface i2s_transmitter_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] left_in;
    logic [WIDTH-1:0] right_in;
    logic             sample_valid;
    logic             sample_ready;
    logic             bclk;
    logic             lrclk;
    logic             sdata;
    logic             underrun;

    modport master (
        output left_in, right_in, sample_valid,
        input  sample_ready, bclk, lrclk, sdata, underrun
    );

    modport slave (
        input  left_in, right_in, sample_valid,
        output sample_ready, bclk, lrclk, sdata, underrun
    );
endinterface

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: registered bclk plus a strobe on the last clk of
// each bclk period (the cycle before bclk falls).
module i2s_clkgen #(
    parameter int BCLK_DIV = 8
) (
    input  logic clk,
    input  logic rstn,
    output logic bclk,
    output logic edge_evt
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(BCLK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;

    assign edge_evt = (div_cnt == LAST);
    assign div_nxt  = edge_evt ? '0 : div_cnt + DW'(1);

    // bclk is registered from the next count so it always equals (div_cnt >= HALF)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bclk    <= (div_nxt >= HALF);
        end
    end
endmodule

// File: rtl/i2s_transmitter.sv
// Double-buffered stereo I2S serialiser, MSB first, zero-padded slots.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified word select timing.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_W,
    parameter int SLOT_BITS = SLOT_W,
    parameter int BCLK_DIV  = 8
) (
    input logic clk,
    input logic rstn,
    i2s_transmitter_if.slave bus
);
    localparam int CW = cnt_width(SLOT_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] SLOT     = CW'(SLOT_BITS);

    logic           edge_evt;
    logic           bclk;
    logic [CW-1:0]  bit_cnt;
    logic [CW-1:0]  bit_nxt;
    logic           frame_wrap;
    stereo_sample_t hold_q;
    stereo_sample_t shift_q;
    stereo_sample_t shift_nxt;
    logic           ready_q;
    logic           lrclk_q;
    logic           sdata_q;
    logic           underrun_q;
    logic           slot_r;
    logic [CW-1:0]  pos;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_sh;
    logic           sdata_nxt;
    logic           lrclk_nxt;

    i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
        .clk      (clk),
        .rstn     (rstn),
        .bclk     (bclk),
        .edge_evt (edge_evt)
    );

    assign frame_wrap = edge_evt && (bit_cnt == LAST_BIT);
    assign bit_nxt    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);

`ifndef I2S_LEFT_JUSTIFIED_EN
    logic [CW-1:0] lead;
    assign lead = (bit_nxt == LAST_BIT) ? '0 : bit_nxt + CW'(1);
`endif

    always_comb begin
        shift_nxt = shift_q;
        if (frame_wrap) begin
            shift_nxt = ready_q ? '0 : hold_q;
        end
        slot_r  = (bit_nxt >= SLOT);
        pos     = slot_r ? bit_nxt - SLOT : bit_nxt;
        word    = slot_r ? shift_nxt.right : shift_nxt.left;
        // padding positions (pos >= WIDTH) shift everything out, giving zero
        word_sh   = word << pos;
        sdata_nxt = word_sh[WIDTH-1];
`ifdef I2S_LEFT_JUSTIFIED_EN
        lrclk_nxt = slot_r;
`else
        lrclk_nxt = (lead >= SLOT);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt    <= '0;
            hold_q     <= '0;
            shift_q    <= '0;
            ready_q    <= 1'b1;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= frame_wrap && ready_q;
            if (edge_evt) begin
                bit_cnt <= bit_nxt;
                shift_q <= shift_nxt;
                lrclk_q <= lrclk_nxt;
                sdata_q <= sdata_nxt;
            end
            // an accept coinciding with an empty load is kept for the next frame
            if (bus.sample_valid && ready_q) begin
                hold_q.left  <= bus.left_in;
                hold_q.right <= bus.right_in;
                ready_q      <= 1'b0;
            end else if (frame_wrap && !ready_q) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.bclk         = bclk;
    assign bus.lrclk        = lrclk_q;
    assign bus.sdata        = sdata_q;
    assign bus.underrun     = underrun_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter (WIDTH=24, SLOT_BITS=32, BCLK_DIV=4).
// A negedge monitor collects the last 64 bits seen at each bclk rise.
module tb_i2s_transmitter;

    localparam int FRAME = 256;
    localparam int NV    = 6;
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;
`else
    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;
`endif

    typedef struct {
        logic        push;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] el;
        logic [23:0] er;
        logic        eur;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    i2s_transmitter_if #(.WIDTH(24)) bus ();

    i2s_transmitter #(.WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic        bclk_d = 1'b0;
    logic [63:0] hist_d = '0;
    logic [63:0] hist_lr = '0;

    always @(negedge clk) begin
        bclk_d <= bus.bclk;
        if (bus.bclk && !bclk_d) begin
            hist_d  <= {hist_d[62:0], bus.sdata};
            hist_lr <= {hist_lr[62:0], bus.lrclk};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] samp_l(int k);
        return 24'h100000 + 24'(k);
    endfunction

    function automatic logic [23:0] samp_r(int k);
        return 24'h200000 + 24'(k);
    endfunction

    vec_t        tbl [NV];
    logic [23:0] fl, fr, pl, pr;
    logic        fur;
    logic        push;
    logic        hs;
    logic [7:0]  bv;
    int          s, start, acc, bad, n;

    initial begin
        tbl[0] = '{1'b1, 24'hA5F00F, 24'h800001, 24'hA5F00F, 24'h800001, 1'b0};
        tbl[1] = '{1'b1, 24'h7FFFFF, 24'h000001, 24'h7FFFFF, 24'h000001, 1'b0};
        tbl[2] = '{1'b0, 24'hDEAD00, 24'h00BEEF, 24'h000000, 24'h000000, 1'b1};
        tbl[3] = '{1'b0, 24'h111111, 24'h222222, 24'h000000, 24'h000000, 1'b1};
        tbl[4] = '{1'b1, 24'h123456, 24'hFEDCBA, 24'h123456, 24'hFEDCBA, 1'b0};
        tbl[5] = '{1'b1, 24'hFFFFFF, 24'h555555, 24'hFFFFFF, 24'h555555, 1'b0};

        rstn = 1'b0;
        bus.sample_valid = 1'b0;
        bus.left_in = '0;
        bus.right_in = '0;
        cyc = 0;
        repeat (3) tick();
        chk("reset_outputs", {bus.bclk, bus.lrclk, bus.sdata, bus.sample_ready, bus.underrun}, 5'b00010);
        rstn = 1'b1;
        cyc = 0;

        fl = '0; fr = '0; fur = 1'b0; pl = '0; pr = '0;
        for (int i = 0; i <= NV + 1; i++) begin
            s = FRAME * i;
            goto(s);
            if (i > 0) begin
                chk("frame_data", hist_d, {pl, 8'h00, pr, 8'h00});
                chk("frame_lrclk", hist_lr, LR_EXP);
            end
            chk("underrun_at_boundary", bus.underrun, fur);
            tick();
            chk("underrun_one_clk", bus.underrun, 1'b0);
            push = (i < NV) && tbl[i].push;
            if (push) begin
                bus.left_in = tbl[i].l;
                bus.right_in = tbl[i].r;
                bus.sample_valid = 1'b1;
            end
            tick();
            bus.sample_valid = 1'b0;
            chk("ready_after_push", bus.sample_ready, !push);
            if (i == 0) begin
                bv = '0;
                for (int k = 0; k < 8; k++) begin
                    bv = {bv[6:0], bus.bclk};
                    tick();
                end
                chk("bclk_toggle", bv, 8'b11001100);
            end
            pl = fl; pr = fr;
            if (i < NV) begin
                fl = tbl[i].el; fr = tbl[i].er; fur = tbl[i].eur;
            end else begin
                fl = '0; fr = '0; fur = 1'b1;
            end
        end

        // continuous valid: one acceptance per frame, sent in order
        n = 0; acc = 0; bad = 0; start = cyc;
        bus.left_in = samp_l(0);
        bus.right_in = samp_r(0);
        bus.sample_valid = 1'b1;
        while (cyc < 2048 + 3 * FRAME) begin
            if ((cyc % FRAME == 0) && (cyc > 2048))
                chk("stream_frame", hist_d, {samp_l((cyc - 2048) / FRAME - 1), 8'h00,
                                             samp_r((cyc - 2048) / FRAME - 1), 8'h00});
            if (bus.sample_ready !== ((cyc % FRAME == 0) || (cyc == start))) bad++;
            hs = bus.sample_ready;
            tick();
            if (hs) begin
                acc++;
                n++;
                bus.left_in = samp_l(n);
                bus.right_in = samp_r(n);
            end
        end
        bus.sample_valid = 1'b0;
        chk("stream_accepts", acc, 4);
        chk("stream_ready_gaps", bad, 0);
        chk("stream_frame_last", hist_d, {samp_l(2), 8'h00, samp_r(2), 8'h00});
        chk("stream_no_underrun", bus.underrun, 1'b0);
        chk("ready_after_load", bus.sample_ready, 1'b1);

        // park a pair in the holding register, then reset mid right slot
        bus.left_in = 24'h3C3C3C;
        bus.right_in = 24'hC3C3C3;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        goto(2816 + 162);
        chk("pre_reset_lrclk", bus.lrclk, 1'b1);
        chk("pre_reset_ready", bus.sample_ready, 1'b0);
        rstn = 1'b0;
        tick();
        chk("midreset_outputs", {bus.bclk, bus.lrclk, bus.sdata, bus.sample_ready, bus.underrun}, 5'b00010);
        rstn = 1'b1;
        cyc = 0;
        bv = '0;
        for (int k = 0; k < 8; k++) begin
            bv = {bv[6:0], bus.bclk};
            tick();
        end
        chk("bclk_after_reset", bv, 8'b00110011);
        goto(FRAME);
        chk("post_reset_frame0", hist_d, 64'h0);
        chk("post_reset_underrun1", bus.underrun, 1'b1);
        goto(2 * FRAME);
        chk("post_reset_dropped", hist_d, 64'h0);
        chk("post_reset_underrun2", bus.underrun, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
